// File: rtl/imem_loader_pkg.sv
// +-----------------------------------------------------------------------------
// | imem_loader_pkg: shared types and constants for the instruction-memory loader.
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package imem_loader_pkg;

  localparam int IMEM_DEPTH = 64;
  localparam int LEN_W      = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/word_assembler.sv
// +-----------------------------------------------------------------------------
// | word_assembler: packs four stream bytes, low byte first, into a 32-bit word.
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [1:0]  r_idx;
  logic [23:0] r_shift;

  // The 4th byte is merged combinationally so the word is available on its accepting edge.
  assign word          = {byte_in, r_shift};
  assign word_complete = byte_en && (r_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_idx   <= 2'd0;
      r_shift <= 24'd0;
    end else if (byte_en) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= {byte_in, r_shift[23:8]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// +-----------------------------------------------------------------------------
// | imem_loader: parses a length-prefixed byte stream into instruction-memory writes
// | and holds the CPU in reset until the image is complete. Option: IMEM_LOADER_CHECKSUM_EN.
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  localparam logic [LEN_W-1:0] c_depth = LEN_W'(DEPTH);

  loader_state_t     r_state;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W:0]   r_word_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_accept;
  logic              w_start_ok;
  logic [LEN_W-1:0]  w_len;
  logic              w_len_bad;
  logic [ADDR_W:0]   w_next_cnt;
  logic              w_last_word;
  logic              w_asm_en;
  logic [31:0]       w_word;
  logic              w_word_complete;

  assign w_accept    = byte_valid && byte_ready;
  assign w_start_ok  = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_len       = {byte_data, r_len[7:0]};
  assign w_len_bad   = (w_len == '0) || (w_len > c_depth);
  assign w_next_cnt  = r_word_cnt + 1'b1;
  assign w_last_word = (LEN_W'(w_next_cnt) == r_len);
  assign w_asm_en    = w_accept && (r_state == DATA);

  word_assembler u_word_assembler (
    .clk           (clk),
    .reset         (reset),
    .clear         (w_start_ok),
    .byte_en       (w_asm_en),
    .byte_in       (byte_data),
    .word          (w_word),
    .word_complete (w_word_complete)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_word_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum     <= 8'd0;
`endif
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      wr_en <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_state    <= LEN0;
            r_word_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
          end
        end
        LEN0: begin
          if (w_accept) begin
            r_len[7:0] <= byte_data;
            r_state    <= LEN1;
          end
        end
        LEN1: begin
          if (w_accept) begin
            r_len <= w_len;
            if (w_len_bad) begin
              r_state    <= ERR;
              err        <= 1'b1;
              busy       <= 1'b0;
              byte_ready <= 1'b0;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (w_accept) r_csum <= r_csum ^ byte_data;
`endif
          if (w_word_complete) begin
            wr_en      <= 1'b1;
            wr_addr    <= r_word_cnt[ADDR_W-1:0];
            wr_data    <= w_word;
            r_word_cnt <= w_next_cnt;
            if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state    <= CHK;
`else
              r_state    <= DONE;
              done       <= 1'b1;
              cpu_hold   <= 1'b0;
              busy       <= 1'b0;
              byte_ready <= 1'b0;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (w_accept) begin
            busy       <= 1'b0;
            byte_ready <= 1'b0;
            if (byte_data == r_csum) begin
              r_state  <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              r_state  <= ERR;
              err      <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state    <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// +-----------------------------------------------------------------------------
// | tb_imem_loader: directed self-checking bench for imem_loader.
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  int checks = 0;
  int errors = 0;

  logic [5:0]  cap_addr[$];
  logic [31:0] cap_data[$];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_hold   (cpu_hold)
  );

  always @(negedge clk) begin
    if (wr_en) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte timeout: byte_ready=%0b required 1", byte_ready);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_status(input string name, input logic [3:0] exp_bdec);
    // order: busy, done, err, cpu_hold
    checks++;
    if ({busy, done, err, cpu_hold} !== exp_bdec) begin
      errors++;
      $display("FAIL %s: busy/done/err/hold=%b required %b", name, {busy, done, err, cpu_hold}, exp_bdec);
    end
  endtask

  task automatic check_writes(input string name, input int n,
                              input logic [31:0] d0, input logic [31:0] d1);
    checks++;
    if (cap_addr.size() != n) begin
      errors++;
      $display("FAIL %s write count: got %0d required %0d", name, cap_addr.size(), n);
    end else begin
      if (n > 0 && (cap_addr[0] !== 6'd0 || cap_data[0] !== d0)) begin
        errors++;
        $display("FAIL %s write0: addr %0d data %h required addr 0 data %h", name, cap_addr[0], cap_data[0], d0);
      end
      if (n > 1 && (cap_addr[1] !== 6'd1 || cap_data[1] !== d1)) begin
        errors++;
        $display("FAIL %s write1: addr %0d data %h required addr 1 data %h", name, cap_addr[1], cap_data[1], d1);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({byte_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_hold} !== {1'b0, 1'b0, 6'd0, 32'd0, 4'b0001}) begin
      errors++;
      $display("FAIL reset_values: ready=%b wr_en=%b addr=%0d data=%h status=%b required 0 0 0 0 0001",
               byte_ready, wr_en, wr_addr, wr_data, {busy, done, err, cpu_hold});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] img[10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL len0_entry: ready=%b busy=%b required 1 1", byte_ready, busy);
    end
    for (int i = 0; i < 10; i++) send_byte(img[i]);
`ifndef IMEM_LOADER_CHECKSUM_EN
    checks++;
    if (wr_en !== 1'b1 || done !== 1'b1 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_with_last_write: wr_en=%b done=%b hold=%b required 1 1 0", wr_en, done, cpu_hold);
    end
`else
    send_byte(8'h90);
`endif
    repeat (3) @(negedge clk);
    check_writes("basic", 2, 32'h00000013, 32'h00100093);
    check_status("basic_final", 4'b0100);
  endtask

  task automatic test_stalled();
    logic [7:0] img[10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      send_byte(img[i]);
      if (i == 4) pulse_start();
      else repeat (3) @(posedge clk);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h90);
`endif
    repeat (3) @(negedge clk);
    check_writes("stalled", 2, 32'h00000013, 32'h00100093);
    check_status("stalled_final", 4'b0100);
  endtask

  task automatic test_bad_length();
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    check_status("len_zero_err", 4'b0011);
    repeat (2) @(negedge clk);
    check_writes("len_zero", 0, 32'd0, 32'd0);
    pulse_start();
    send_byte(8'h41);
    send_byte(8'h00);
    check_status("len_65_err", 4'b0011);
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL len_65_ready: got %b required 0", byte_ready);
    end
  endtask

  task automatic test_full_memory();
    int bad;
    logic [31:0] exp;
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    send_byte(8'h40);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (cap_addr.size() != 64) begin
      errors++;
      $display("FAIL full_count: got %0d required 64", cap_addr.size());
    end else begin
      bad = 0;
      for (int k = 0; k < 64; k++) begin
        exp = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        if (cap_addr[k] !== 6'(k) || cap_data[k] !== exp) begin
          if (bad == 0)
            $display("FAIL full_word %0d: addr %0d data %h required addr %0d data %h", k, cap_addr[k], cap_data[k], k, exp);
          bad++;
        end
      end
      if (bad != 0) errors++;
    end
    check_status("full_final", 4'b0100);
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] hdr_and_7[9] = '{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(hdr_and_7[i]);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'h08;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    checks++;
    if ({byte_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_hold} !== {1'b0, 1'b0, 6'd0, 32'd0, 4'b0001}) begin
      errors++;
      $display("FAIL midreset_values: ready=%b wr_en=%b addr=%0d data=%h status=%b required 0 0 0 0 0001",
               byte_ready, wr_en, wr_addr, wr_data, {busy, done, err, cpu_hold});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_writes("midreset_partial", 1, 32'h04030201, 32'd0);
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'haa);
    send_byte(8'hbb);
    send_byte(8'hcc);
    send_byte(8'hdd);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    repeat (3) @(negedge clk);
    check_writes("reload", 1, 32'hddccbbaa, 32'd0);
    check_status("reload_final", 4'b0100);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    logic [7:0] img[10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(img[i]);
    send_byte(8'h91);
    check_status("csum_bad_err", 4'b0011);
    repeat (2) @(negedge clk);
    check_writes("csum_bad", 2, 32'h00000013, 32'h00100093);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stalled();
    test_bad_length();
    test_full_memory();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
